// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between two valid/ready requesters.
// The accepted operation is latched into ALU drive registers and held for
// HOLD_CYCLES cycles. The sum and zero flag are then captured and returned
// to the owning requester through a valid/ready response port.
// Optional macro ALU_OP_CHECK_EN: gin codes outside the legal set get an
// immediate err=1 response and are never issued to the ALU.
module alu_share_ctrl #(
    parameter int WIDTH       = 32,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_err,
    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err,
    // ALU side
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_gin,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_zout,
    output logic             busy
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             last;      // requester served most recently
    logic             owner;     // requester that owns the op in flight
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             err_q;

    logic             accept;
    logic             pick1;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;
    logic             illegal;
    logic             rsp_hs;

`ifdef ALU_OP_CHECK_EN
    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b010, 3'b110, 3'b111, 3'b000, 3'b001: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    endfunction
`endif

    // Round-robin grant: a lone valid wins; on contention the side not served last wins.
    always_comb begin
        pick1      = req1_valid && (!req0_valid || !last);
        accept     = (state == IDLE) && !reset && (req0_valid || req1_valid);
        req0_ready = accept && !pick1;
        req1_ready = accept && pick1;
        sel_a      = pick1 ? req1_a  : req0_a;
        sel_b      = pick1 ? req1_b  : req0_b;
        sel_op     = pick1 ? req1_op : req0_op;
`ifdef ALU_OP_CHECK_EN
        illegal    = !op_legal(sel_op);
`else
        illegal    = 1'b0;
`endif
        rsp_hs     = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
    end

    // Controller FSM: accept, hold the ALU inputs, capture, then hand the result back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last       <= 1'b1;   // requester 0 wins the first contention
            owner      <= 1'b0;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_gin    <= 3'b010;
            result_q   <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= pick1;
                        if (illegal) begin
                            // Rejected op: answer straight away, leave the ALU inputs alone.
                            result_q   <= '0;
                            zero_q     <= 1'b0;
                            err_q      <= 1'b1;
                            rsp0_valid <= !pick1;
                            rsp1_valid <= pick1;
                            state      <= RESP;
                        end else begin
                            alu_a   <= sel_a;
                            alu_b   <= sel_b;
                            alu_gin <= sel_op;
                            err_q   <= 1'b0;
                            cnt     <= CW'(HOLD_CYCLES - 1);
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        result_q   <= alu_sum;
                        zero_q     <= alu_zout;
                        rsp0_valid <= !owner;
                        rsp1_valid <= owner;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        last       <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One shared result register feeds both response ports; only the valids differ.
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;
    assign rsp0_err    = err_q;
    assign rsp1_err    = err_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl. u_dut uses HOLD_CYCLES=1 and u_dut4 uses
// HOLD_CYCLES=4 for the latency and mid-operation reset cases.
// The illegal-op expectations follow ALU_OP_CHECK_EN.
module tb_alu_share_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // ALU reference, hand-written from the gin encoding
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] g);
        case (g)
            3'b010:  alu_f = a + b;
            3'b110:  alu_f = a - b;
            3'b111:  alu_f = {31'b0, ($signed(a) < $signed(b))};
            3'b000:  alu_f = a & b;
            3'b001:  alu_f = a | b;
            default: alu_f = a ^ b;
        endcase
    endfunction

    // ---------------- DUT with HOLD_CYCLES=1 ----------------
    logic        reset;
    logic        r0v, r1v, r0r, r1r, s0v, s1v, s0r, s1r;
    logic [31:0] r0a, r0b, r1a, r1b, s0res, s1res;
    logic [2:0]  r0op, r1op;
    logic        s0z, s1z, s0e, s1e;
    logic [31:0] aa, ab, asum;
    logic [2:0]  agin;
    logic        azout, busy;

    assign asum  = alu_f(aa, ab, agin);
    assign azout = (asum == 32'd0);

    alu_share_ctrl #(.WIDTH(32), .HOLD_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
        .rsp0_valid(s0v), .rsp0_ready(s0r), .rsp0_result(s0res), .rsp0_zero(s0z), .rsp0_err(s0e),
        .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
        .rsp1_valid(s1v), .rsp1_ready(s1r), .rsp1_result(s1res), .rsp1_zero(s1z), .rsp1_err(s1e),
        .alu_a(aa), .alu_b(ab), .alu_gin(agin), .alu_sum(asum), .alu_zout(azout), .busy(busy)
    );

    // ---------------- DUT with HOLD_CYCLES=4 ----------------
    logic        q_rst;
    logic        q0v, q0r, q1r, qs0v, qs1v, qs0r;
    logic [31:0] q0a, q0b, qs0res, qs1res;
    logic [2:0]  q0op;
    logic        qs0z, qs1z, qs0e, qs1e;
    logic [31:0] qaa, qab, qsum;
    logic [2:0]  qgin;
    logic        qzout, qbusy;
    logic        q1v = 1'b0;
    logic        qs1r = 1'b0;
    logic [31:0] q1a = '0;
    logic [31:0] q1b = '0;
    logic [2:0]  q1op = 3'b010;

    assign qsum  = alu_f(qaa, qab, qgin);
    assign qzout = (qsum == 32'd0);

    alu_share_ctrl #(.WIDTH(32), .HOLD_CYCLES(4)) u_dut4 (
        .clk(clk), .reset(q_rst),
        .req0_valid(q0v), .req0_ready(q0r), .req0_a(q0a), .req0_b(q0b), .req0_op(q0op),
        .rsp0_valid(qs0v), .rsp0_ready(qs0r), .rsp0_result(qs0res), .rsp0_zero(qs0z), .rsp0_err(qs0e),
        .req1_valid(q1v), .req1_ready(q1r), .req1_a(q1a), .req1_b(q1b), .req1_op(q1op),
        .rsp1_valid(qs1v), .rsp1_ready(qs1r), .rsp1_result(qs1res), .rsp1_zero(qs1z), .rsp1_err(qs1e),
        .alu_a(qaa), .alu_b(qab), .alu_gin(qgin), .alu_sum(qsum), .alu_zout(qzout), .busy(qbusy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the given response valid is seen (sampled 1 after the edge).
    task automatic wait_rsp(input int who, input int maxc, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if ((who == 0) ? s0v : s1v) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        // ---------------- reset with both valids high ----------------
        reset = 1'b1; q_rst = 1'b1;
        r0v = 1'b1; r0a = 32'd1; r0b = 32'd1; r0op = 3'b010;
        r1v = 1'b1; r1a = 32'd1; r1b = 32'd1; r1op = 3'b010;
        s0r = 1'b0; s1r = 1'b0;
        q0v = 1'b0; q0a = '0; q0b = '0; q0op = 3'b010; qs0r = 1'b1;
        repeat (3) tick();
        chk("rst_req0_ready", 32'(r0r), 32'd0);
        chk("rst_req1_ready", 32'(r1r), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp0_valid", 32'(s0v), 32'd0);
        chk("rst_rsp1_valid", 32'(s1v), 32'd0);
        chk("rst_alu_gin", 32'(agin), 32'd2);
        chk("rst_alu_a", aa, 32'd0);
        chk("rst_alu_b", ab, 32'd0);
        chk("rst_result", s0res, 32'd0);
        chk("rst_err", 32'(s0e), 32'd0);

        // ---------------- single ADD 5+7 ----------------
        r0v = 1'b0; r1v = 1'b0;
        reset = 1'b0; q_rst = 1'b0;
        tick();
        r0v = 1'b1; r0a = 32'd5; r0b = 32'd7; r0op = 3'b010; s0r = 1'b1;
        #1;
        chk("add_req0_ready", 32'(r0r), 32'd1);
        chk("add_req1_ready", 32'(r1r), 32'd0);
        tick();                                  // accepted
        r0v = 1'b0;
        chk("add_busy", 32'(busy), 32'd1);
        chk("add_ready_exec", 32'(r0r), 32'd0);
        chk("add_valid_early", 32'(s0v), 32'd0);
        chk("add_alu_a", aa, 32'd5);
        tick();
        chk("add_valid", 32'(s0v), 32'd1);
        chk("add_rsp1_valid", 32'(s1v), 32'd0);
        chk("add_result", s0res, 32'd12);
        chk("add_zero", 32'(s0z), 32'd0);
        chk("add_err", 32'(s0e), 32'd0);
        tick();                                  // handshake taken
        chk("add_valid_clr", 32'(s0v), 32'd0);
        chk("add_idle", 32'(busy), 32'd0);

        // ---------------- contention from reset ----------------
        reset = 1'b1;
        r0v = 1'b1; r0a = 32'd9;          r0b = 32'd9; r0op = 3'b110;
        r1v = 1'b1; r1a = 32'hFFFF_FFFF;  r1b = 32'd1; r1op = 3'b111;
        s0r = 1'b1; s1r = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("ct_first_req0", 32'(r0r), 32'd1);
        chk("ct_first_req1", 32'(r1r), 32'd0);
        tick();                                  // req0 SUB accepted
        r0a = 32'h0000_000C; r0b = 32'h0000_000A; r0op = 3'b000;
        wait_rsp(0, 6, "ct_sub");
        chk("ct_sub_result", s0res, 32'd0);
        chk("ct_sub_zero", 32'(s0z), 32'd1);
        tick();                                  // handshake -> IDLE
        chk("ct_second_req1", 32'(r1r), 32'd1);
        chk("ct_second_req0", 32'(r0r), 32'd0);
        tick();                                  // req1 SLT accepted
        r1a = 32'd1; r1b = 32'd1; r1op = 3'b010;
        wait_rsp(1, 6, "ct_slt");
        chk("ct_slt_result", s1res, 32'd1);
        chk("ct_slt_rsp0_valid", 32'(s0v), 32'd0);
        tick();
        chk("ct_third_req0", 32'(r0r), 32'd1);
        chk("ct_third_req1", 32'(r1r), 32'd0);
        tick();                                  // req0 AND accepted
        r0v = 1'b0; r1v = 1'b0;
        wait_rsp(0, 6, "ct_and");
        chk("ct_and_result", s0res, 32'h8);
        tick();

        // ---------------- backpressure on requester 1 ----------------
        s1r = 1'b0;
        r1v = 1'b1; r1a = 32'h0000_00F0; r1b = 32'h0000_000F; r1op = 3'b001;
        tick();                                  // req1 OR accepted
        r1v = 1'b0;
        r0v = 1'b1; r0a = 32'd2; r0b = 32'd3; r0op = 3'b010;
        wait_rsp(1, 6, "bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(s1v), 32'd1);
            chk("bp_result", s1res, 32'hFF);
            chk("bp_req0_ready", 32'(r0r), 32'd0);
            tick();
        end
        s1r = 1'b1;
        #1;
        chk("bp_req0_ready_hs", 32'(r0r), 32'd0);
        tick();                                  // handshake taken
        chk("bp_valid_clr", 32'(s1v), 32'd0);
        chk("bp_req0_next", 32'(r0r), 32'd1);
        tick();                                  // req0 ADD accepted
        r0v = 1'b0;
        wait_rsp(0, 6, "bp_add");
        chk("bp_add_result", s0res, 32'd5);
        tick();

        // ---------------- illegal op 011 ----------------
        r0v = 1'b1; r0a = 32'd3; r0b = 32'd5; r0op = 3'b011;
        tick();                                  // accepted
        r0v = 1'b0;
`ifdef ALU_OP_CHECK_EN
        chk("ill_valid", 32'(s0v), 32'd1);
        chk("ill_err", 32'(s0e), 32'd1);
        chk("ill_result", s0res, 32'd0);
        chk("ill_zero", 32'(s0z), 32'd0);
        chk("ill_alu_gin", 32'(agin), 32'd2);
        chk("ill_alu_a", aa, 32'd2);
        tick();
        chk("ill_valid_clr", 32'(s0v), 32'd0);
`else
        chk("ill_valid_early", 32'(s0v), 32'd0);
        chk("ill_alu_gin", 32'(agin), 32'd3);
        wait_rsp(0, 6, "ill");
        chk("ill_result", s0res, 32'd6);
        chk("ill_err", 32'(s0e), 32'd0);
        tick();
`endif

        // ---------------- HOLD_CYCLES=4: latency ----------------
        q0v = 1'b1; q0a = 32'd1; q0b = 32'd2; q0op = 3'b010;
        #1;
        chk("h4_ready", 32'(q0r), 32'd1);
        tick();                                  // accepted at this edge
        q0v = 1'b0;
        tick(); tick(); tick();
        chk("h4_valid_early", 32'(qs0v), 32'd0);
        tick();
        chk("h4_valid", 32'(qs0v), 32'd1);
        chk("h4_result", qs0res, 32'd3);
        tick();

        // ---------------- HOLD_CYCLES=4: reset in EXEC ----------------
        q0v = 1'b1; q0a = 32'd4; q0b = 32'd4; q0op = 3'b110;
        tick();                                  // accepted
        q0v = 1'b0;
        tick();
        chk("mr_in_exec", 32'(qbusy), 32'd1);
        q_rst = 1'b1;
        tick();
        chk("mr_busy", 32'(qbusy), 32'd0);
        chk("mr_valid", 32'(qs0v), 32'd0);
        chk("mr_alu_a", qaa, 32'd0);
        chk("mr_alu_gin", 32'(qgin), 32'd2);
        chk("mr_ready", 32'(q0r), 32'd0);
        q_rst = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (qs0v) seen = 1'b1;
            end
            chk("mr_no_rsp", 32'(seen), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Arbitrates one 32-bit ALU (gin op encoding, zero flag out) between two requesters.
- Accepts one operation at a time over a valid/ready request port and drives the ALU from latched operands.
- Holds for a programmable settle time, then returns the registered result and zero flag over a valid/ready response port.
- Sits between the ALU instance and two clients, e.g. the main datapath and an address/compare unit.

Parameters:
WIDTH, 32, operand/result width
HOLD_CYCLES, 1, cycles the ALU inputs are held before capture; must be >=1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_a  in  WIDTH  operand a
req0_b  in  WIDTH  operand b
req0_op  in  3  gin code
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 takes result
rsp0_result  out  WIDTH  captured ALU sum
rsp0_zero  out  1  captured zero flag
rsp0_err  out  1  illegal-op flag (see Optional Feature)
req1_* / rsp1_*  same set as requester 0, for requester 1
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_gin  out  3  to ALU gin
alu_sum  in  WIDTH  from ALU sum
alu_zout  in  1  from ALU zout
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on `reset`.
- Legal gin codes: 010 ADD, 110 SUB, 111 SLT, 000 AND, 001 OR.
- States: IDLE, EXEC, RESP. Reset -> IDLE.
- Reset values: rsp*_valid=0, rsp*_result=0, rsp*_zero=0, rsp*_err=0, alu_a=0, alu_b=0, alu_gin=3'b010, busy=0.
- Round-robin pointer resets so that requester 0 wins the first contention.
- IDLE:
  - reqN_ready = (state==IDLE) && grant==N. This is combinational from valids and the pointer; it is never high outside IDLE.
  - Only one ready is high per cycle.
  - If exactly one valid, grant it.
  - If both valid, grant the requester not served last.
  - On accept, latch a/b/op into the ALU drive registers, record the owner, load counter=HOLD_CYCLES-1, and go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_gin come from the drive registers, which are stable for the whole op.
  - When counter==0, capture alu_sum -> result and alu_zout -> zero, then go to RESP. Otherwise decrement.
- RESP:
  - rsp<owner>_valid=1; the other response valid stays 0.
  - Result, zero and err are held stable until rsp<owner>_ready=1.
  - On the handshake, clear valid, update the pointer to the owner, and go to IDLE.
  - A new accept is possible on the following cycle.
- Latency: accept on edge t -> rsp_valid high from cycle t+HOLD_CYCLES+1. With HOLD_CYCLES=1, valid is high the 2nd cycle after accept.
- Max throughput: one op per HOLD_CYCLES+2 cycles.
- Drive registers retain their last values outside EXEC; they are not cleared.
- Backpressure: while in EXEC/RESP both reqN_ready are 0. A pending request from either side waits with no loss.
- Response results are kept in one shared register; only the owner's rsp valid is asserted.
- Reset mid-operation (any state) aborts the op: no response is issued, all outputs take their reset values, and the pointer resets.
- Requester deasserting valid in IDLE before ready is allowed; the grant simply moves.

Optional Feature:
- Macro ALU_OP_CHECK_EN.
- Defined:
  - In IDLE, an accepted op with a code outside the legal set skips EXEC and goes directly to RESP.
  - Response carries result=0, zero=0, err=1. The ALU drive registers are not updated.
  - Legal ops respond with err=0.
- Undefined:
  - rsp*_err is tied 0.
  - Any code is forwarded to the ALU unchanged and whatever the ALU returns is captured.

Test Plan:
- Reset: hold reset 3 cycles with both valids high -> both ready=0, busy=0, rsp valids 0, alu_gin=010, alu_a=alu_b=0.
- req0 ADD a=5 b=7, HOLD_CYCLES=1, rsp0_ready=1 -> req0_ready 1 cycle; rsp0_valid 2 cycles later; result=12, zero=0, err=0.
- Contention: both valid from reset.
  - req0 SUB 9,9 is granted first -> result=0, zero=1.
  - Then req1 SLT a=32'hFFFFFFFF b=1 -> result=1.
  - A third pair with both valid goes to req0 again.
- Backpressure: req1 OR a=32'hF0 b=32'h0F with rsp1_ready low 5 cycles; req0 valid meanwhile.
  - rsp1_valid held, result=32'hFF stable, req0_ready=0 throughout.
  - req0 is accepted the cycle after the rsp1 handshake.
- Reset mid-operation: assert reset in EXEC with HOLD_CYCLES=4 -> no rsp_valid ever appears for that op; state IDLE, outputs at reset values next cycle.
- Illegal op: op=3'b011.
  - ALU_OP_CHECK_EN defined -> rsp valid 1 cycle after accept, err=1, result=0, alu_gin unchanged.
  - Undefined -> alu_gin=011 in EXEC and err=0.
